// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters
// and returns each sampled result over a valid/ready response port tagged with the requester id.
module alu_arbiter #(
    parameter int WIDTH       = 8,
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [2:0]       r0_op,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [2:0]       r1_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opco,
    output logic             alu_power,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_sign,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_sign,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

    state_e           state_q;
    logic             last_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_opco_q;
    logic             alu_power_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_carry_q;
    logic             rsp_sign_q;
    logic             rsp_zero_q;
    logic [CNT_W-1:0] op_count_q;

    logic             gnt_id;
    logic             accept;
    logic [WIDTH-1:0] gnt_a;
    logic [WIDTH-1:0] gnt_b;
    logic [2:0]       gnt_op;

    // When both request, the one not served last wins.
    always_comb begin
        gnt_id = 1'b0;
        if (r0_valid && r1_valid) begin
            gnt_id = ~last_q;
        end else if (r1_valid) begin
            gnt_id = 1'b1;
        end
        gnt_a  = gnt_id ? r1_a  : r0_a;
        gnt_b  = gnt_id ? r1_b  : r0_b;
        gnt_op = gnt_id ? r1_op : r0_op;
    end

    // NOTE: ready is qualified with rst_n so it drops the instant reset asserts, not at the next edge.
    assign accept   = rst_n && (state_q == S_IDLE) && (r0_valid || r1_valid);
    assign r0_ready = accept && !gnt_id;
    assign r1_ready = accept &&  gnt_id;

    // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opco_q   <= '0;
            alu_power_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_sign_q   <= 1'b0;
            rsp_zero_q   <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rsp_id_q <= gnt_id;
                        if (gnt_op != 3'd0) begin
                            alu_a_q     <= gnt_a;
                            alu_b_q     <= gnt_b;
                            alu_opco_q  <= gnt_op;
                            alu_power_q <= 1'b1;
                            cnt_q       <= EXEC_LOAD;
                            state_q     <= S_EXEC;
                        end else begin
                            rsp_result_q <= '0;
                            rsp_carry_q  <= 1'b0;
                            rsp_sign_q   <= 1'b0;
                            rsp_zero_q   <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt_q == 4'd1) begin
                        rsp_result_q <= alu_result;
                        rsp_carry_q  <= alu_carry;
                        rsp_sign_q   <= alu_sign;
                        rsp_zero_q   <= alu_zero;
                        rsp_valid_q  <= 1'b1;
                        alu_power_q  <= 1'b0;
                        alu_a_q      <= '0;
                        alu_b_q      <= '0;
                        alu_opco_q   <= '0;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + CNT_W'(1);
                        last_q      <= rsp_id_q;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opco   = alu_opco_q;
    assign alu_power  = alu_power_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_sign   = rsp_sign_q;
    assign rsp_zero   = rsp_zero_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a stub ALU, a transaction-level reference model and
// a negedge monitor that checks grants, ALU drive, response timing/content and op_count.
module tb_alu_arbiter;

    localparam int WIDTH = 8;
    localparam int EXEC  = 3;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic       carry;
        logic       sign;
        logic       zero;
        logic [7:0] result;
    } alu_out_t;

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        alu_out_t   exp;
        int         t_acc;
    } txn_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             r0_valid = 1'b0, r1_valid = 1'b0;
    logic             r0_ready, r1_ready;
    logic [WIDTH-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [2:0]       r0_op = '0, r1_op = '0;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [2:0]       alu_opco;
    logic             alu_power, alu_carry, alu_sign, alu_zero;
    logic             rsp_valid, rsp_id, rsp_carry, rsp_sign, rsp_zero;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    txn_t             sb[$];
    int               grant_log[$];
    logic             last_id = 1'b1;
    logic [CNT_W-1:0] model_cnt = '0;
    logic [7:0]       last_result;
    logic             last_carry;
    logic             last_rsp_id;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_arbiter #(.WIDTH(WIDTH), .EXEC_CYCLES(EXEC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opco(alu_opco), .alu_power(alu_power),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_sign(rsp_sign), .rsp_zero(rsp_zero), .op_count(op_count)
    );

    function automatic alu_out_t alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] w;
        alu_out_t   o;
        case (op)
            3'd1:    w = {1'b0, a} + {1'b0, b};
            3'd2:    w = {1'b0, a} - {1'b0, b};
            3'd3:    w = {1'b0, a & b};
            3'd4:    w = {1'b0, a | b};
            3'd5:    w = {1'b0, a ^ b};
            3'd6:    w = {a, 1'b0};
            3'd7:    w = {a[0], 1'b0, a[7:1]};
            default: w = '0;
        endcase
        o.result = w[7:0];
        o.carry  = w[8];
        o.sign   = w[7];
        o.zero   = (w[7:0] == 8'd0);
        return o;
    endfunction

    // Stub of the shared ALU: outputs are all zero while unpowered.
    alu_out_t alu_out;
    assign alu_out    = alu_power ? alu_fn(alu_a, alu_b, alu_opco) : '0;
    assign alu_result = alu_out.result;
    assign alu_carry  = alu_out.carry;
    assign alu_sign   = alu_out.sign;
    assign alu_zero   = alu_out.zero;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_r0_ready"},  32'(r0_ready),  32'd0);
        check({tag, "_r1_ready"},  32'(r1_ready),  32'd0);
        check({tag, "_alu_power"}, 32'(alu_power), 32'd0);
        check({tag, "_alu_a"},     32'(alu_a),     32'd0);
        check({tag, "_alu_b"},     32'(alu_b),     32'd0);
        check({tag, "_alu_opco"},  32'(alu_opco),  32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_rsp_res"},   32'(rsp_result), 32'd0);
        check({tag, "_rsp_flags"}, 32'({rsp_carry, rsp_sign, rsp_zero}), 32'd0);
        check({tag, "_op_count"},  32'(op_count),  32'd0);
    endtask

    // Monitor: reference model of grant rule, EXEC window, response timing and content.
    txn_t mt;
    logic exp_r0, exp_r1, win, in_exec, exp_valid;
    int   rise;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_r0 = 1'b0;
            exp_r1 = 1'b0;
            if (sb.size() == 0 && (r0_valid || r1_valid)) begin
                win    = (r0_valid && r1_valid) ? ~last_id : r1_valid;
                exp_r0 = ~win;
                exp_r1 = win;
            end
            check("r0_ready", 32'(r0_ready), 32'(exp_r0));
            check("r1_ready", 32'(r1_ready), 32'(exp_r1));

            in_exec   = 1'b0;
            exp_valid = 1'b0;
            if (sb.size() > 0) begin
                mt        = sb[0];
                rise      = (mt.op == 3'd0) ? mt.t_acc + 1 : mt.t_acc + EXEC + 1;
                in_exec   = (mt.op != 3'd0) && (cyc > mt.t_acc) && (cyc <= mt.t_acc + EXEC);
                exp_valid = (cyc >= rise);
            end
            check("alu_power", 32'(alu_power), 32'(in_exec));
            check("alu_a",     32'(alu_a),     in_exec ? 32'(mt.a)  : 32'd0);
            check("alu_b",     32'(alu_b),     in_exec ? 32'(mt.b)  : 32'd0);
            check("alu_opco",  32'(alu_opco),  in_exec ? 32'(mt.op) : 32'd0);
            check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            check("op_count",  32'(op_count),  32'(model_cnt));

            if (rsp_valid && exp_valid) begin
                check("rsp_id",     32'(rsp_id),     32'(mt.id));
                check("rsp_result", 32'(rsp_result), 32'(mt.exp.result));
                check("rsp_carry",  32'(rsp_carry),  32'(mt.exp.carry));
                check("rsp_sign",   32'(rsp_sign),   32'(mt.exp.sign));
                check("rsp_zero",   32'(rsp_zero),   32'(mt.exp.zero));
                if (rsp_ready) begin
                    last_result = rsp_result;
                    last_carry  = rsp_carry;
                    last_rsp_id = rsp_id;
                    last_id     = mt.id;
                    model_cnt   = model_cnt + 1'b1;
                    void'(sb.pop_front());
                end
            end

            if ((r0_valid && r0_ready) || (r1_valid && r1_ready)) begin
                mt.id    = r1_ready;
                mt.a     = r1_ready ? r1_a  : r0_a;
                mt.b     = r1_ready ? r1_b  : r0_b;
                mt.op    = r1_ready ? r1_op : r0_op;
                mt.exp   = (mt.op == 3'd0) ? '0 : alu_fn(mt.a, mt.b, mt.op);
                mt.t_acc = cyc;
                sb.push_back(mt);
                grant_log.push_back(int'(mt.id));
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        sb.delete();
        last_id   = 1'b1;
        model_cnt = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Present one request and hold it until granted; scramble the port afterwards.
    task automatic request(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int n;
        if (id) begin r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op; end
        else    begin r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op; end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? r1_ready : r0_ready) && n < 50);
        check("accept_seen", 32'(id ? r1_ready : r0_ready), 32'd1);
        @(posedge clk);
        #1;
        if (id) begin r1_valid = 1'b0; r1_a = 8'($urandom); r1_b = 8'($urandom); r1_op = 3'($urandom); end
        else    begin r0_valid = 1'b0; r0_a = 8'($urandom); r0_b = 8'($urandom); r0_op = 3'($urandom); end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        #1;
        check_all_zero("por");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Single request: 7 + 4.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        request(1'b0, 8'd7, 8'd4, 3'd1);
        wait_drain();
        check("single_result", 32'(last_result), 32'd11);
        check("single_id",     32'(last_rsp_id), 32'd0);
        @(posedge clk); #1;
        check("single_count",  32'(op_count),    32'd1);

        // Fairness: both valid from reset, rsp_ready held high.
        apply_reset();
        grant_log.delete();
        rsp_ready = 1'b1;
        n = 0;
        while (grant_log.size() < 4 && n < 100) begin
            r0_valid = 1'b1; r0_a = 8'($urandom); r0_b = 8'($urandom); r0_op = 3'($urandom);
            r1_valid = 1'b1; r1_a = 8'($urandom); r1_b = 8'($urandom); r1_op = 3'($urandom);
            @(negedge clk);
            @(posedge clk); #1;
            n++;
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        wait_drain();
        check("fair_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("fair_grant", 32'(grant_log[i]), 32'(i % 2));
        @(posedge clk); #1;
        check("fair_op_count", 32'(op_count), 32'd4);

        // Backpressure with r1 waiting.
        rsp_ready = 1'b0;
        request(1'b0, 8'd100, 8'd30, 3'd2);
        r1_valid = 1'b1; r1_a = 8'd9; r1_b = 8'd3; r1_op = 3'd5;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_r1_ready",  32'(r1_ready),  32'd0);
            check("bp_alu_power", 32'(alu_power), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_r1_ready", 32'(r1_ready), 32'd0);
        @(negedge clk);
        check("bp_next_accept", 32'(r1_ready), 32'd1);
        @(posedge clk); #1;
        r1_valid = 1'b0;
        wait_drain();

        // NOP then add with carry out.
        request(1'b1, 8'd55, 8'd66, 3'd0);
        wait_drain();
        check("nop_result", 32'(last_result), 32'd0);
        request(1'b0, 8'd250, 8'd10, 3'd1);
        wait_drain();
        check("carry_result", 32'(last_result), 32'd4);
        check("carry_flag",   32'(last_carry),  32'd1);

        // Randomized traffic with random backpressure; op_count wraps several times.
        for (int i = 0; i < 700; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) r0_valid = 1'($urandom);
            if ($urandom_range(0, 3) == 0) r1_valid = 1'($urandom);
            r0_a = 8'($urandom); r0_b = 8'($urandom); r0_op = 3'($urandom);
            r1_a = 8'($urandom); r1_b = 8'($urandom); r1_op = 3'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        r0_valid  = 1'b0;
        r1_valid  = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();

        // Reset during the 2nd EXEC cycle.
        request(1'b0, 8'd20, 8'd22, 3'd1);
        @(posedge clk);
        #2;
        check("mid_power_before", 32'(alu_power), 32'd1);
        apply_reset();
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("mid_op_count", 32'(op_count), 32'd0);
        @(posedge clk); #1;
        request(1'b1, 8'd15, 8'd15, 3'd3);
        wait_drain();
        check("post_reset_id",     32'(last_rsp_id), 32'd1);
        check("post_reset_result", 32'(last_result), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
